round_arb: RTL and testbench



---
 rtl/round_arb.sv | 100 ++++++++++
 tb/tb_round_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/round_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | round_arb: round-robin arbiter feeding a shared 2-stage rounding pipeline.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module round_arb #(
  parameter int NUM_REQ = 4,
  parameter int IN_WID  = 16,
  parameter int OUT_WID = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ*IN_WID-1:0]    req_dat,
  input  logic [NUM_REQ-1:0]           req_vld,
  output logic [NUM_REQ-1:0]           req_rdy,
  input  logic                         cfg_en,
  input  logic [NUM_REQ-1:0]           cfg_mask,
  output logic [OUT_WID-1:0]           rsp_dat,
  output logic                         rsp_vld,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TRUNC = IN_WID - OUT_WID;
  localparam logic [IN_WID-1:0] HALF = IN_WID'(1) << (TRUNC - 1);

  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    win;
  logic               found;
  int unsigned        idx;
  logic               xfer;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [IN_WID-1:0]  win_dat, s1_d;

  logic               s1_vld_q;
  logic [ID_W-1:0]    s1_id_q;
  logic [IN_WID-1:0]  s1_dat_q;
  logic               rsp_vld_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [OUT_WID-1:0] rsp_dat_q;

  assign elig = req_vld & ~cfg_mask & {NUM_REQ{cfg_en}};

  // First eligible index at or after ptr, wrapping around.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    req_rdy = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found        = 1'b1;
        win          = ID_W'(idx);
        req_rdy[idx] = 1'b1;
      end
    end
  end

  assign xfer    = |(req_vld & req_rdy);
  assign ptr_d   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  assign win_dat = req_dat[win*IN_WID +: IN_WID];
  // All-ones upper field is passed through so the add can never wrap.
  assign s1_d    = (&win_dat[IN_WID-1:TRUNC]) ? win_dat : win_dat + HALF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_id_q   <= '0;
      s1_dat_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_dat_q <= '0;
    end else begin
      if (xfer) begin
        ptr_q    <= ptr_d;
        s1_id_q  <= win;
        s1_dat_q <= s1_d;
      end
      s1_vld_q  <= xfer;
      rsp_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        rsp_dat_q <= s1_dat_q[IN_WID-1:TRUNC];
        rsp_id_q  <= s1_id_q;
      end
    end
  end

  logic unused_lsbs;
  assign unused_lsbs = ^s1_dat_q[TRUNC-1:0];

  assign rsp_dat = rsp_dat_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_id  = rsp_id_q;
  assign busy    = s1_vld_q | rsp_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_round_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_round_arb: scoreboard bench for round_arb against a behavioural model.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_round_arb;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int OW = 10;
  localparam int TR = IW - OW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*IW-1:0] req_dat;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_rdy;
  logic            cfg_en;
  logic [N-1:0]    cfg_mask;
  logic [OW-1:0]   rsp_dat;
  logic            rsp_vld;
  logic [1:0]      rsp_id;
  logic            busy;

  round_arb #(.NUM_REQ(N), .IN_WID(IW), .OUT_WID(OW)) dut (
    .clk(clk), .rst_n(rst_n), .req_dat(req_dat), .req_vld(req_vld),
    .req_rdy(req_rdy), .cfg_en(cfg_en), .cfg_mask(cfg_mask),
    .rsp_dat(rsp_dat), .rsp_vld(rsp_vld), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int id; int dat; } exp_t;
  exp_t     q[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       cyc   = 0;
  int       m_ptr = 0;
  int       c_win;
  int       exp_rdy;
  int       last_dat = 0;
  int       last_id  = 0;
  logic [N-1:0] granted_now = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-half-up on the top OW bits, with saturation-free bypass for all-ones.
  function automatic int ref_round(input int d);
    int hi;
    hi = d >> TR;
    if (hi == (1 << OW) - 1) return hi;
    return ((d + (1 << (TR - 1))) % (1 << IW)) >> TR;
  endfunction

  // Stimulus-side model: predict the grant, push the expected response.
  always begin
    @(posedge clk);
    #4;
    granted_now = '0;
    if (!rst_n) begin
      m_ptr = 0;
    end else begin
      c_win = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (c_win < 0 && req_vld[i] && !cfg_mask[i] && cfg_en) c_win = i;
      end
      exp_rdy = (c_win < 0) ? 0 : (1 << c_win);
      chk("req_rdy", int'(req_rdy), exp_rdy);
      if (c_win >= 0) begin
        q.push_back('{cyc + 2, c_win, ref_round(int'(req_dat[c_win*IW +: IW]))});
        m_ptr = (c_win + 1) % N;
        granted_now[c_win] = 1'b1;
      end
    end
  end

  // Response monitor.
  always begin
    exp_t e;
    @(posedge clk);
    #3;
    if (!rst_n) begin
      q.delete();
      last_dat = 0;
      last_id  = 0;
    end
    chk("busy", int'(busy), int'(q.size() != 0));
    if (rsp_vld) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got id %0d dat %0h expected no response (cycle %0d)",
                 rsp_id, rsp_dat, cyc);
      end else begin
        e = q.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_id", int'(rsp_id), e.id);
        chk("rsp_dat", int'(rsp_dat), e.dat);
        last_dat = e.dat;
        last_id  = e.id;
      end
    end else begin
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_rsp: got rsp_vld 0 expected id %0d dat %0h (cycle %0d)",
                 e.id, e.dat, cyc);
      end
      chk("rsp_dat_hold", int'(rsp_dat), last_dat);
      chk("rsp_id_hold", int'(rsp_id), last_id);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] rnd_dat();
    case ($urandom_range(0, 7))
      0: return 16'hFFFF;
      1: return 16'hFFC0;
      2: return 16'hFFBF;
      3: return 16'h001F;
      4: return 16'h0020;
      default: return IW'($urandom);
    endcase
  endfunction

  initial begin
    logic [IW-1:0] rvals [4];
    rvals = '{16'h001F, 16'h7FE0, 16'hFFC0, 16'hFFFF};
    rst_n = 1'b0; cfg_en = 1'b1; cfg_mask = '0; req_vld = '0; req_dat = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_rsp_vld", int'(rsp_vld), 0);
    chk("reset_rsp_dat", int'(rsp_dat), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_busy", int'(busy), 0);
    step();
    rst_n = 1'b1;

    // single request
    req_vld = 4'b0001; req_dat[15:0] = 16'h0020;
    step();
    req_vld = '0;
    repeat (3) step();

    // rounding boundaries on requester 2
    req_vld = 4'b0100;
    for (int j = 0; j < 4; j++) begin
      req_dat[2*IW +: IW] = rvals[j];
      step();
    end
    req_vld = '0;
    repeat (3) step();

    // bring pointer to 0, then fairness over all four
    req_vld = 4'b1000; step();
    req_vld = 4'b1111; repeat (8) step();
    req_vld = '0; repeat (3) step();

    // masking
    cfg_mask = 4'b0100; req_vld = 4'b0110;
    repeat (5) step();
    cfg_mask = '0;
    repeat (2) step();
    req_vld = '0; repeat (3) step();

    // drain on cfg_en drop
    req_vld = 4'b1000; repeat (4) step();
    cfg_en = 1'b0; repeat (4) step();
    cfg_en = 1'b1; step();
    req_vld = '0; repeat (3) step();

    // reset while both stages hold samples
    req_vld = 4'b0001; repeat (2) step();
    req_vld = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_vld", int'(rsp_vld), 0);
    chk("midrst_rsp_dat", int'(rsp_dat), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (2) step();
    rst_n = 1'b1;
    req_vld = 4'b1111; repeat (2) step();
    req_vld = '0; repeat (3) step();

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 19) == 0) cfg_mask = N'($urandom_range(0, 15));
      cfg_en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_vld[i] || granted_now[i]) begin
          req_vld[i] = ($urandom_range(0, 2) != 0);
          req_dat[i*IW +: IW] = rnd_dat();
        end
      end
      step();
    end

    req_vld = '0; cfg_en = 1'b1; cfg_mask = '0;
    repeat (6) step();
    chk("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
